// File: rtl/weyl_pkg.sv
// Shared types and elaboration-time helpers for the Weyl bitstream generator.
// Provides the quota width, the modular inverse of the stride and the
// per-channel starting accumulator value.
package weyl_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Quota width: holds 0..n inclusive.
   function automatic int unsigned qw(input int unsigned n);
      return 32'($clog2(n)) + 32'd1;
   endfunction

   // Inverse of an odd stride modulo a power-of-two n (exhaustive over odd residues).
   function automatic int unsigned mod_inverse(input int unsigned stride, input int unsigned n);
      int unsigned inv;
      inv = 0;
      for (int unsigned i = 1; i < n; i += 2) begin
         if (inv == 0 && ((64'(stride) * 64'(i)) % 64'(n)) == 64'd1) begin
            inv = i;
         end
      end
      return inv;
   endfunction

   // Table index that lands on bit position 0 for a given base phase.
   function automatic int unsigned idx0(input int unsigned n, input int unsigned phase,
                                        input int unsigned inv);
      longint unsigned back;
      back = 64'(n - (phase % n));
      return 32'((back * 64'(inv)) % 64'(n));
   endfunction

endpackage

// File: rtl/weyl_stream_gen_if.sv
// Quota-in / bitstream-out handshake bundle.
// slave  : the generator (accepts quotas, drives the bit beats).
// master : the environment (supplies quotas, consumes beats).
interface weyl_stream_gen_if #(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned QW       = 7
);
   logic                   in_valid;
   logic                   in_ready;
   logic [CHANNELS*QW-1:0] in_quota;
   logic                   out_valid;
   logic                   out_ready;
   logic [CHANNELS-1:0]    out_bits;
   logic                   out_last;

   modport slave (
      input  in_valid, in_quota, out_ready,
      output in_ready, out_valid, out_bits, out_last
   );

   modport master (
      output in_valid, in_quota, out_ready,
      input  in_ready, out_valid, out_bits, out_last
   );
endinterface

// File: rtl/weyl_chan_bit.sv
// One channel of the Weyl generator: latched quota plus an index accumulator.
// Ports: clk/rst, load_i (capture quota, restart idx), adv_i (step idx),
//        quota_i (raw quota), bit_c (idx < quota, combinational from flops).
module weyl_chan_bit
   import weyl_pkg::*;
#(
   parameter int unsigned N    = 64,
   parameter int unsigned QW   = 7,
   parameter int unsigned IDX0 = 0,
   parameter int unsigned INV  = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_i,
   input  logic          adv_i,
   input  logic [QW-1:0] quota_i,
   output logic          bit_c
);

   localparam int unsigned LW = $clog2(N);

   logic [LW-1:0] idx_q, idx_d;
   logic [QW-1:0] q_q, q_d;

   // Load wins over advance so a chained frame restarts cleanly.
   always_comb begin
      idx_d = idx_q;
      q_d   = q_q;
      if (load_i) begin
         idx_d = LW'(IDX0);
         q_d   = (quota_i > QW'(N)) ? QW'(N) : quota_i;
      end else if (adv_i) begin
         // Power-of-two N: natural wrap of the LW-bit adder is the mod.
         idx_d = idx_q + LW'(INV);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q <= '0;
         q_q   <= '0;
      end else begin
         idx_q <= idx_d;
         q_q   <= q_d;
      end
   end

   assign bit_c = (QW'(idx_q) < q_q);

endmodule

// File: rtl/weyl_stream_gen.sv
// Multi-channel serial Weyl stochastic bitstream generator.
// Accepts one quota per channel, then streams BITSTREAM beats of CHANNELS bits.
// Ports: clk, rst (async, active-high), bus (weyl_stream_gen_if.slave:
//        in_valid/in_ready/in_quota, out_valid/out_ready/out_bits/out_last),
//        busy (frame in progress).
// Optional: define WEYL_CHAIN_EN to accept the next quota vector on the last
//           beat so frames run back-to-back without an idle cycle.
module weyl_stream_gen
   import weyl_pkg::*;
#(
   parameter int unsigned BITSTREAM = 64,
   parameter int unsigned CHANNELS  = 4,
   parameter int unsigned BASE      = 61,
   parameter int unsigned STRIDE    = 17,
   parameter int unsigned CH_OFFSET = 0
) (
   input  logic             clk,
   input  logic             rst,
   weyl_stream_gen_if.slave bus,
   output logic             busy
);

   localparam int unsigned QW  = qw(BITSTREAM);
   localparam int unsigned LW  = $clog2(BITSTREAM);
   localparam int unsigned INV = mod_inverse(STRIDE, BITSTREAM);

   if (STRIDE % 2 == 0) begin : g_bad_stride
      $error("weyl_stream_gen: STRIDE must be odd");
   end
   if (BITSTREAM < 4 || (BITSTREAM & (BITSTREAM - 1)) != 0) begin : g_bad_len
      $error("weyl_stream_gen: BITSTREAM must be a power of two >= 4");
   end

   state_t        state_q, state_d;
   logic [LW-1:0] t_q, t_d;

   logic                in_ready_c;
   logic                out_valid_c;
   logic                last_beat_c;
   logic                load_c;
   logic                adv_c;
   logic [CHANNELS-1:0] bits_c;

   // State and beat counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         t_q     <= '0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
      end
   end

   // Next state and beat counter.
   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      case (state_q)
         IDLE: if (load_c) state_d = RUN;
         RUN:  if (adv_c && last_beat_c && !load_c) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (load_c) begin
         t_d = '0;
      end else if (adv_c) begin
         t_d = t_q + LW'(1);
      end
   end

   // Handshakes and beat outputs.
   always_comb begin
      last_beat_c = (t_q == LW'(BITSTREAM - 1));
      out_valid_c = (state_q == RUN);
      in_ready_c  = (state_q == IDLE);
`ifdef WEYL_CHAIN_EN
      if (state_q == RUN && last_beat_c && bus.out_ready) begin
         in_ready_c = 1'b1;
      end
`endif
      load_c        = bus.in_valid & in_ready_c;
      adv_c         = out_valid_c & bus.out_ready;
      bus.in_ready  = in_ready_c;
      bus.out_valid = out_valid_c;
      bus.out_last  = out_valid_c & last_beat_c;
      // Latched quotas survive the frame; gate so IDLE shows all zeros.
      bus.out_bits  = out_valid_c ? bits_c : '0;
      busy          = out_valid_c;
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      weyl_chan_bit #(
         .N    (BITSTREAM),
         .QW   (QW),
         .IDX0 (idx0(BITSTREAM, BASE + 32'(c) * CH_OFFSET, INV)),
         .INV  (INV)
      ) u_chan (
         .clk     (clk),
         .rst     (rst),
         .load_i  (load_c),
         .adv_i   (adv_c),
         .quota_i (bus.in_quota[c*QW +: QW]),
         .bit_c   (bits_c[c])
      );
   end

endmodule
